error_capture_serial: RTL and testbench
=======================================

# error_capture_serial

Multi-channel error capture and serial readout unit for the test-chip top. It takes the per-bit error vectors (`b1_error`) from up to `NCH` decoder instances. It accumulates saturating per-channel bit-error counts and a frame count. It snapshots one frame's error vectors and shifts them out one bit per channel per `ShiftEn` strobe, with `KeepShift` framing the transfer. It generalises the fixed two-channel error register to parametrised channel count, frame length and counter width, and adds on-chip counting, overflow and missed-frame flags.

## Interface
Parameters:
- `FL`, 104, frame length: bits per error vector and per serial transfer
- `NCH`, 2, number of decoder channels
- `CW`, 16, width of each per-channel error counter
- `FW`, 8, width of the frame counter

Ports:
- `Clock`  in  1  single clock; all state is on its rising edge
- `nReset`  in  1  asynchronous, active-low reset
- `Ready`  in  1  frame event: error vectors are presented this cycle
- `Valid`  in  NCH  per-channel qualifier for `b1_error`
- `b1_error`  in  NCH*FL  error vectors; channel c occupies bits [c*FL +: FL]
- `ShiftEn`  in  1  one-cycle shift strobe, generated by the divided clock enable
- `Clear`  in  1  synchronous clear of counters and flags
- `KeepShift`  out  1  high while a snapshot is being shifted out
- `BitOut`  out  NCH  current serial bit per channel
- `ErrCount`  out  NCH*CW  saturating bit-error count; channel c at [c*CW +: CW]
- `FrameCount`  out  FW  number of frame events, wraps modulo 2^FW
- `Overflow`  out  NCH  sticky flag: channel counter saturated
- `Missed`  out  1  sticky flag: a frame event arrived while a shift was in progress

## Operation
- Reset: all outputs are 0, FSM is IDLE, shift registers are 0 and the bit counter is 0.
- Counting on every cycle with `Ready`=1:
  - `FrameCount` increments by 1, wrapping.
  - For each c with `Valid[c]`=1, the popcount of the channel vector (width ceil(log2(FL+1))) is added to `ErrCount[c]`.
  - If the true sum exceeds 2^CW-1, `ErrCount[c]` saturates at 2^CW-1 and `Overflow[c]` is set.
  - Channels with `Valid[c]`=0 are not counted.
- FSM states: IDLE and SHIFT.
- IDLE with `Ready`=1:
  - Each channel's vector is loaded into its FL-bit shift register; a channel with `Valid[c]`=0 loads all zeros.
  - The bit counter is cleared and the FSM goes to SHIFT.
- IDLE with `ShiftEn`=1: ignored.
- SHIFT:
  - `KeepShift`=1 and `BitOut[c]` = LSB of the channel-c shift register.
  - On each `ShiftEn`, all registers shift right (zero-fill) and the bit counter increments.
  - The `ShiftEn` that takes the counter from FL-1 to FL returns the FSM to IDLE.
- `Ready`=1 while in SHIFT: counting proceeds normally, no snapshot is taken, and `Missed` is set. This includes the cycle of the final `ShiftEn`.
- `Clear`=1:
  - Zeroes `ErrCount`, `FrameCount`, `Overflow` and `Missed`.
  - Clear has priority: a `Ready` in the same cycle is not counted. It still causes a snapshot if the FSM is IDLE.
  - Clear does not abort a shift in progress.
- In IDLE, `BitOut` is 0.

## Timing
- Counters and flags update on the edge after the `Ready` cycle (latency 1).
- For a snapshot taken from `Ready` in cycle N:
  - `KeepShift`=1 from cycle N+1.
  - Bit 0 of each vector is on `BitOut` in cycle N+1.
  - After the k-th `ShiftEn`, bit k is presented on the following cycle.
- `KeepShift` falls on the cycle after the FL-th `ShiftEn` is accepted.
- Total transfer takes exactly FL `ShiftEn` strobes and is independent of the strobe spacing. `ShiftEn` is allowed in cycle N+1.
- An asynchronous reset mid-shift immediately returns all state to the reset values.

## Test plan
- Reset and idle: hold `nReset`=0, then release with no `Ready` → all outputs 0. `ShiftEn` pulses leave `KeepShift`=0.
- Single frame, NCH=2:
  - Stimulus: `Ready`=1 and `Valid`=2'b11 for one cycle, ch0 vector = 0x5 (2 ones), ch1 = all-ones (104).
  - Response: next cycle `ErrCount`={104,2}, `FrameCount`=1, `KeepShift`=1, `BitOut`=2'b11.
- Serial readout:
  - Stimulus: after the single frame, `ShiftEn` every 4 cycles.
  - Response: ch0 serial stream is 1,0,1,0,0… and ch1 is 104 ones. `KeepShift` falls exactly the cycle after the 104th strobe.
- Saturation:
  - Stimulus: CW=8, repeat frames of 104 errors on ch0 with `Valid[0]`=1.
  - Response: `ErrCount[0]`=104, then 208, then 255 with `Overflow[0]`=1. `ErrCount[1]` stays 0 while `Valid[1]`=0.
- Missed and Clear:
  - Stimulus: `Ready` during SHIFT.
  - Response: counted and `Missed`=1, with the shifted data unchanged.
  - Stimulus: `Clear` plus `Ready` in IDLE.
  - Response: counters 0, snapshot taken, `KeepShift`=1.
- Reset mid-shift:
  - Stimulus: drop `nReset` after 50 strobes.
  - Response: `KeepShift`, `BitOut` and counters are 0 immediately. The next `Ready` starts a fresh transfer from bit 0.

Source files
------------

// File: rtl/error_capture_serial_if.sv
// Bus between the error capture unit and its environment: frame/qualifier/error inputs,
// serial readout and counter/flag outputs.
interface error_capture_serial_if #(
   parameter int unsigned FL  = 104,
   parameter int unsigned NCH = 2,
   parameter int unsigned CW  = 16,
   parameter int unsigned FW  = 8
);
   logic                Ready;
   logic [NCH-1:0]      Valid;
   logic [NCH*FL-1:0]   b1_error;
   logic                ShiftEn;
   logic                Clear;
   logic                KeepShift;
   logic [NCH-1:0]      BitOut;
   logic [NCH*CW-1:0]   ErrCount;
   logic [FW-1:0]       FrameCount;
   logic [NCH-1:0]      Overflow;
   logic                Missed;

   modport master (
      output Ready, Valid, b1_error, ShiftEn, Clear,
      input  KeepShift, BitOut, ErrCount, FrameCount, Overflow, Missed
   );

   modport slave (
      input  Ready, Valid, b1_error, ShiftEn, Clear,
      output KeepShift, BitOut, ErrCount, FrameCount, Overflow, Missed
   );
endinterface

// File: rtl/error_capture_serial.sv
// Multi-channel error capture: saturating per-channel bit-error counters, frame counter,
// and a per-channel snapshot shifted out LSB-first, one bit per ShiftEn strobe.
module error_capture_serial #(
   parameter int unsigned FL  = 104,
   parameter int unsigned NCH = 2,
   parameter int unsigned CW  = 16,
   parameter int unsigned FW  = 8
) (
   input logic                     Clock,
   input logic                     nReset,
   error_capture_serial_if.slave   bus
);

   localparam int unsigned PCW = $clog2(FL + 1);
   localparam int unsigned SW  = ((CW > PCW) ? CW : PCW) + 1;
   localparam int unsigned BCW = $clog2(FL + 1);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_keep;
   logic                     w_load;
   logic                     w_shift;
   logic                     w_miss_evt;

   logic [NCH-1:0][FL-1:0]   r_shift;
   logic [BCW-1:0]           r_bit_cnt;
   logic [NCH-1:0][CW-1:0]   r_err;
   logic [FW-1:0]            r_fc;
   logic [NCH-1:0]           r_ov;
   logic                     r_miss;

   logic [NCH-1:0][PCW-1:0]  w_pop;
   logic [NCH-1:0][SW-1:0]   w_sum;
   logic [NCH-1:0]           w_sat;
   logic [NCH-1:0]           w_bitout;

   // State register; KeepShift is registered from the next state so it tracks SHIFT exactly
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= ST_IDLE;
         r_keep  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_keep  <= (w_state_nxt == ST_SHIFT);
      end
   end

   // Next-state: leave SHIFT on the strobe that moves the bit counter from FL-1 to FL
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.Ready) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (bus.ShiftEn && (r_bit_cnt == BCW'(FL - 1))) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM controls: snapshot only from IDLE, frames arriving mid-shift are flagged as missed
   always_comb begin
      w_load     = 1'b0;
      w_shift    = 1'b0;
      w_miss_evt = 1'b0;
      case (r_state)
         ST_IDLE:  w_load = bus.Ready;
         ST_SHIFT: begin
            w_shift    = bus.ShiftEn;
            w_miss_evt = bus.Ready;
         end
         default: ;
      endcase
   end

   // Snapshot shift registers and transfer bit counter
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
      end else if (w_load) begin
         for (int unsigned c = 0; c < NCH; c++)
            r_shift[c] <= bus.Valid[c] ? bus.b1_error[c*FL +: FL] : '0;
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         for (int unsigned c = 0; c < NCH; c++)
            r_shift[c] <= {1'b0, r_shift[c][FL-1:1]};
         r_bit_cnt <= r_bit_cnt + BCW'(1);
      end
   end

   // Per-channel popcount and widened sum for saturation detection
   always_comb begin
      for (int unsigned c = 0; c < NCH; c++) begin
         w_pop[c] = '0;
         for (int unsigned b = 0; b < FL; b++)
            w_pop[c] = w_pop[c] + PCW'(bus.b1_error[c*FL + b]);
         w_sum[c] = SW'(r_err[c]) + SW'(w_pop[c]);
         w_sat[c] = (w_sum[c] > SW'(CNT_MAX));
      end
   end

   // Counters and sticky flags; Clear wins over a same-cycle Ready
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_err  <= '0;
         r_fc   <= '0;
         r_ov   <= '0;
         r_miss <= 1'b0;
      end else if (bus.Clear) begin
         r_err  <= '0;
         r_fc   <= '0;
         r_ov   <= '0;
         r_miss <= 1'b0;
      end else if (bus.Ready) begin
         r_fc <= r_fc + FW'(1);
         for (int unsigned c = 0; c < NCH; c++) begin
            if (bus.Valid[c]) begin
               if (w_sat[c]) begin
                  r_err[c] <= CNT_MAX;
                  r_ov[c]  <= 1'b1;
               end else begin
                  r_err[c] <= CW'(w_sum[c]);
               end
            end
         end
         if (w_miss_evt) r_miss <= 1'b1;
      end
   end

   always_comb begin
      for (int unsigned c = 0; c < NCH; c++)
         w_bitout[c] = r_shift[c][0] & r_keep;
   end

   assign bus.KeepShift  = r_keep;
   assign bus.BitOut     = w_bitout;
   assign bus.ErrCount   = r_err;
   assign bus.FrameCount = r_fc;
   assign bus.Overflow   = r_ov;
   assign bus.Missed     = r_miss;

endmodule

// File: tb/tb_error_capture_serial.sv
// Scoreboard bench for error_capture_serial: directed scenarios then random traffic,
// expected outputs from an integer/array reference model.
module tb_error_capture_serial;

   localparam int unsigned FL   = 104;
   localparam int unsigned NCH  = 2;
   localparam int unsigned CW   = 8;
   localparam int unsigned FW   = 8;
   localparam int          MAXC = (1 << CW) - 1;

   typedef struct {
      int                 tag;
      logic               keep;
      logic [NCH-1:0]     bits;
      logic [NCH*CW-1:0]  err;
      logic [FW-1:0]      fc;
      logic [NCH-1:0]     ov;
      logic               miss;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_cmp;
   int   n_bad;
   exp_t q[$];

   // reference model state
   int          m_cnt[NCH];
   int          m_fc;
   bit          m_ov[NCH];
   bit          m_miss;
   bit          m_shifting;
   int          m_pos;
   logic [FL-1:0] m_snap[NCH];

   error_capture_serial_if #(.FL(FL), .NCH(NCH), .CW(CW), .FW(FW)) bif ();

   error_capture_serial #(.FL(FL), .NCH(NCH), .CW(CW), .FW(FW)) dut (
      .Clock  (clk),
      .nReset (rst_n),
      .bus    (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: compare DUT outputs with the entry scheduled for this cycle
   always @(negedge clk) begin
      if (rst_n) begin
         while (q.size() > 0 && q[0].tag < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stale_entry: tag %0d never checked (now %0d)", q[0].tag, cyc);
            void'(q.pop_front());
         end
         if (q.size() > 0 && q[0].tag == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("KeepShift",  64'(bif.KeepShift),  64'(e.keep));
            chk("BitOut",     64'(bif.BitOut),     64'(e.bits));
            chk("ErrCount",   64'(bif.ErrCount),   64'(e.err));
            chk("FrameCount", 64'(bif.FrameCount), 64'(e.fc));
            chk("Overflow",   64'(bif.Overflow),   64'(e.ov));
            chk("Missed",     64'(bif.Missed),     64'(e.miss));
         end
      end
   end

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c]  = 0;
         m_ov[c]   = 1'b0;
         m_snap[c] = '0;
      end
      m_fc = 0; m_miss = 1'b0; m_shifting = 1'b0; m_pos = 0;
   endtask

   task automatic model_step(input logic rdy, input logic [NCH-1:0] vld,
                             input logic [NCH*FL-1:0] vec, input logic sen, input logic clr);
      int s;
      if (clr) begin
         for (int c = 0; c < NCH; c++) begin m_cnt[c] = 0; m_ov[c] = 1'b0; end
         m_fc = 0; m_miss = 1'b0;
      end else if (rdy) begin
         m_fc = (m_fc + 1) % (1 << FW);
         for (int c = 0; c < NCH; c++) begin
            if (vld[c]) begin
               s = m_cnt[c] + $countones(vec[c*FL +: FL]);
               if (s > MAXC) begin m_cnt[c] = MAXC; m_ov[c] = 1'b1; end
               else m_cnt[c] = s;
            end
         end
         if (m_shifting) m_miss = 1'b1;
      end
      if (!m_shifting) begin
         if (rdy) begin
            for (int c = 0; c < NCH; c++) m_snap[c] = vld[c] ? vec[c*FL +: FL] : '0;
            m_pos = 0;
            m_shifting = 1'b1;
         end
      end else if (sen) begin
         m_pos++;
         if (m_pos == FL) m_shifting = 1'b0;
      end
   endtask

   function automatic exp_t model_expect();
      exp_t e;
      e.tag  = 0;
      e.keep = m_shifting;
      e.fc   = FW'(m_fc);
      e.miss = m_miss;
      for (int c = 0; c < NCH; c++) begin
         e.bits[c]          = m_shifting ? m_snap[c][m_pos] : 1'b0;
         e.err[c*CW +: CW]  = CW'(m_cnt[c]);
         e.ov[c]            = m_ov[c];
      end
      return e;
   endfunction

   // Drive one cycle of inputs and schedule the expected post-edge outputs
   task automatic step(input logic rdy, input logic [NCH-1:0] vld,
                       input logic [NCH*FL-1:0] vec, input logic sen, input logic clr);
      exp_t e;
      bif.Ready = rdy; bif.Valid = vld; bif.b1_error = vec; bif.ShiftEn = sen; bif.Clear = clr;
      model_step(rdy, vld, vec, sen, clr);
      e = model_expect();
      e.tag = cyc + 1;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n, input logic sen);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, sen, 1'b0);
   endtask

   // Strobe until the model's transfer completes; sp==0 picks random spacing per strobe
   task automatic shift_out(input int sp);
      int gap;
      for (int k = 0; k < 4 * FL && m_shifting; k++) begin
         gap = (sp == 0) ? $urandom_range(1, 4) : sp;
         if (gap > 1) idle(gap - 1, 1'b0);
         step(1'b0, '0, '0, 1'b1, 1'b0);
      end
   endtask

   function automatic logic [NCH*FL-1:0] rand_vec();
      logic [NCH*FL-1:0] v;
      for (int i = 0; i < NCH*FL; i++) v[i] = 1'($urandom_range(0, 1));
      return v;
   endfunction

   task automatic drain();
      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain: %0d entries left unchecked", q.size());
         q.delete();
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_KeepShift"},  64'(bif.KeepShift),  64'd0);
      chk({tag, "_BitOut"},     64'(bif.BitOut),     64'd0);
      chk({tag, "_ErrCount"},   64'(bif.ErrCount),   64'd0);
      chk({tag, "_FrameCount"}, 64'(bif.FrameCount), 64'd0);
      chk({tag, "_Overflow"},   64'(bif.Overflow),   64'd0);
      chk({tag, "_Missed"},     64'(bif.Missed),     64'd0);
   endtask

   task automatic do_reset(input string tag);
      drain();
      rst_n = 1'b0;
      #1;
      check_reset_state(tag);
      model_reset();
      bif.Ready = 1'b0; bif.Valid = '0; bif.b1_error = '0; bif.ShiftEn = 1'b0; bif.Clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NCH*FL-1:0] v;
      cyc = 0; n_cmp = 0; n_bad = 0;
      rst_n = 1'b0;
      bif.Ready = 1'b0; bif.Valid = '0; bif.b1_error = '0; bif.ShiftEn = 1'b0; bif.Clear = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("por");
      rst_n = 1'b1;

      // idle strobes must not start a transfer
      idle(4, 1'b1);
      idle(2, 1'b0);

      // single frame then readout every 4 cycles
      v = '0;
      v[2:0] = 3'b101;
      v[2*FL-1:FL] = '1;
      step(1'b1, 2'b11, v, 1'b0, 1'b0);
      shift_out(4);
      idle(3, 1'b0);

      // saturation on ch0 with ch1 unqualified
      step(1'b0, '0, '0, 1'b0, 1'b1);
      v = rand_vec();
      v[FL-1:0] = '1;
      repeat (3) step(1'b1, 2'b01, v, 1'b0, 1'b0);
      shift_out(1);
      idle(2, 1'b0);

      // frame during shift is counted and flagged, data untouched
      step(1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b1, 2'b11, rand_vec(), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin idle(1, 1'b0); idle(1, 1'b1); end
      step(1'b1, 2'b11, rand_vec(), 1'b0, 1'b0);
      shift_out(3);

      // Clear plus Ready in IDLE: not counted but snapshotted
      step(1'b1, 2'b11, rand_vec(), 1'b0, 1'b1);
      idle(1, 1'b0);
      shift_out(1);

      // reset in the middle of a transfer
      step(1'b1, 2'b11, rand_vec(), 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin idle(1, 1'b0); idle(1, 1'b1); end
      do_reset("midshift");
      step(1'b1, 2'b10, rand_vec(), 1'b0, 1'b0);
      shift_out(0);
      idle(2, 1'b0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         v = rand_vec();
         if ($urandom_range(0, 3) == 0) v[FL-1:0] = '1;
         if ($urandom_range(0, 3) == 0) v[2*FL-1:FL] = '1;
         step(1'($urandom_range(0, 24) == 0), NCH'($urandom), v,
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 299) == 0));
      end
      idle(3, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
